// File: rtl/motor_pkg.sv
// Shared types and constants for the wheel-motor ramp sequencer.
// Both wheel channels import this package.
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_REV_DOWN,
        ST_DEAD,
        ST_ESTOP
    } state_e;

    localparam logic DIR_FWD   = 1'b0;
    localparam logic DIR_REV   = 1'b1;
    localparam int   DEF_WIDTH = 10;

endpackage

// File: rtl/ramp_prescaler.sv
// Ramp step prescaler: counts 0..STEP_DIV-1 while enabled and pulses tick_o
// on the last count. The counter sits at zero whenever it is cleared.
module ramp_prescaler #(
    parameter int STEP_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Soft-start / reversal sequencer in front of one wheel PWM generator.
// Slew-limits duty toward the commanded target and flips direction only at zero duty.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int STEP_DIV    = 1000,
    parameter int STEP        = 8,
    parameter int DEAD_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_duty_i,
    input  logic             cmd_dir_i,
    input  logic             estop_i,
    output logic [WIDTH-1:0] duty_o,
    output logic             dir_o,
    output logic             busy_o,
    output logic             at_target_o
);
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [WIDTH:0] STEP_X   = (WIDTH + 1)'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
    logic             pend_dir_q, pend_dir_d;
    logic [DW-1:0]    dead_q, dead_d;

    logic             ramping, accept, tick;
    logic             up;
    logic [WIDTH:0]   duty_x, tgt_x, diff_x, mag_x, nxt_x;

    assign ramping     = (state_q == ST_RAMP) || (state_q == ST_REV_DOWN);
    assign cmd_ready_o = !estop_i && ((state_q == ST_IDLE) || (state_q == ST_RAMP) ||
                                      (state_q == ST_HOLD));
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign busy_o      = (state_q == ST_RAMP) || (state_q == ST_REV_DOWN) ||
                         (state_q == ST_DEAD) || (state_q == ST_ESTOP);
    assign at_target_o = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign duty_o      = duty_q;
    assign dir_o       = dir_q;

    ramp_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .clr_i  (accept || !ramping),
        .en_i   (ramping),
        .tick_o (tick)
    );

    // One extra bit keeps the step from wrapping past either rail.
    always_comb begin
        duty_x = {1'b0, duty_q};
        tgt_x  = {1'b0, target_q};
        up     = tgt_x > duty_x;
        diff_x = up ? (tgt_x - duty_x) : (duty_x - tgt_x);
        mag_x  = (diff_x < STEP_X) ? diff_x : STEP_X;
        nxt_x  = up ? (duty_x + mag_x) : (duty_x - mag_x);
    end

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        target_d    = target_q;
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
        dead_d      = '0;

        if (estop_i) begin
            duty_d      = '0;
            target_d    = '0;
            pend_duty_d = '0;
            pend_dir_d  = DIR_FWD;
            state_d     = ST_ESTOP;
        end else begin
            case (state_q)
                ST_ESTOP: state_d = ST_IDLE;
                ST_DEAD: begin
                    if (dead_q == DEAD_LAST) begin
                        dir_d    = pend_dir_q;
                        target_d = pend_duty_q;
                        state_d  = (pend_duty_q != '0) ? ST_RAMP : ST_IDLE;
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
                ST_RAMP, ST_REV_DOWN: begin
                    if (tick) begin
                        duty_d = nxt_x[WIDTH-1:0];
                        if (nxt_x == tgt_x) begin
                            if (state_q == ST_REV_DOWN)
                                state_d = ST_DEAD;
                            else
                                state_d = (target_q != '0) ? ST_HOLD : ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase

            // Accept sees the post-step duty so a same-edge tick is never lost.
            if (accept) begin
                if (cmd_dir_i == dir_q) begin
                    target_d = cmd_duty_i;
                    if (cmd_duty_i != duty_d)
                        state_d = ST_RAMP;
                    else
                        state_d = (cmd_duty_i != '0) ? ST_HOLD : ST_IDLE;
                end else begin
                    pend_duty_d = cmd_duty_i;
                    pend_dir_d  = cmd_dir_i;
                    target_d    = '0;
                    state_d     = (duty_d != '0) ? ST_REV_DOWN : ST_DEAD;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            duty_q      <= '0;
            dir_q       <= DIR_FWD;
            target_q    <= '0;
            pend_duty_q <= '0;
            pend_dir_q  <= DIR_FWD;
            dead_q      <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            target_q    <= target_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            dead_q      <= dead_d;
        end
    end

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
Soft-start / direction-reversal sequencer placed in front of one wheel-motor PWM generator in the vacuum drive path. It accepts target duty/direction commands from the navigation logic and drives a slew-limited duty word into the PWM counter comparator. Direction reversal through the H-bridge never happens under load: the block ramps to zero, holds a dead time, then flips direction. An emergency stop forces zero duty immediately.

Parameters:
WIDTH, 10, duty word width; must match the PWM generator's counter width.
STEP_DIV, 1000, clocks per ramp step (prescaler period), >=2.
STEP, 8, maximum duty change per ramp step, 1..2^WIDTH-1.
DEAD_CYCLES, 16, clocks duty is held at 0 before a direction flip, >=1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  new target command present
cmd_ready  out  1  command can be accepted this cycle
cmd_duty  in  WIDTH  target duty (0 = stop, 2^WIDTH-1 = max)
cmd_dir  in  1  target direction (0 fwd, 1 rev)
estop  in  1  emergency stop, level sensitive
duty  out  WIDTH  current duty to the PWM generator, registered
dir  out  1  current H-bridge direction, registered
busy  out  1  ramp, reversal or estop in progress
at_target  out  1  duty == target and no reversal pending

Behaviour:
- Reset (rst_n low at a clk edge): duty=0, dir=0, target=0, pending cleared, prescaler=0, state IDLE; cmd_ready=1, busy=0, at_target=1. Reset mid-ramp aborts the ramp with no further duty steps.
- States: IDLE (duty 0, settled), RAMP (moving toward target), HOLD (duty==target!=0), REV_DOWN (ramping to 0 before flip), DEAD (dead-time count), ESTOP.
- Handshake: accept = cmd_valid & cmd_ready. cmd_ready=1 in IDLE, RAMP and HOLD; 0 in REV_DOWN, DEAD and ESTOP, and whenever estop=1.
- On accept with cmd_dir==dir: target<=cmd_duty; prescaler cleared; next state RAMP if cmd_duty!=duty, else HOLD (or IDLE when 0). A new accept in RAMP retargets without a glitch; the direction of the ramp may reverse.
- On accept with cmd_dir!=dir: pending target/dir stored; target<=0; REV_DOWN if duty!=0, else DEAD directly. The flip always goes through DEAD, even from duty 0.
- Prescaler counts 0..STEP_DIV-1 in RAMP/REV_DOWN and is cleared on accept. A tick occurs when count==STEP_DIV-1. On a tick, duty moves toward target by min(STEP, |target-duty|). Compare and subtract are done in WIDTH+1 bits, so duty never overshoots or wraps (e.g. 1016 -> 1023 with STEP=8).
- The first step lands STEP_DIV clocks after the accept edge.
- RAMP -> HOLD/IDLE on the edge where duty becomes target. REV_DOWN -> DEAD on the edge where duty becomes 0.
- DEAD: counter runs DEAD_CYCLES clocks with duty=0. On the last one, dir<=pending dir, target<=pending target, state RAMP, or IDLE if the pending target is 0.
- estop=1 at any edge (except while reset is active): duty<=0 on that edge, target and pending cleared, state ESTOP. dir is unchanged.
- ESTOP persists while estop=1. The first edge with estop=0 goes to IDLE, and cmd_ready=1 the cycle after.
- Priority: rst_n > estop > DEAD/tick update > command accept. A command presented while estop=1 is not accepted.
- busy=1 in RAMP, REV_DOWN, DEAD and ESTOP. at_target=1 only in IDLE/HOLD.

Decomposition:
- Shared package motor_pkg: state enum (IDLE, RAMP, HOLD, REV_DOWN, DEAD, ESTOP), DIR_FWD/DIR_REV constants, default WIDTH.
- One sub-module, ramp_prescaler: STEP_DIV counter with sync clear and enable, emitting a one-clock tick; reused by the other wheel channel.
- FSM, saturating step arithmetic and dead-time counter stay in motor_ramp_ctrl.

Test Plan:
(Bench parameters: WIDTH=10, STEP_DIV=4, STEP=8, DEAD_CYCLES=3.)
1. Reset: hold rst_n=0 for 2 clocks, release -> duty=0, dir=0, cmd_ready=1, busy=0, at_target=1. Reasserting rst_n during a ramp -> duty=0 at the next edge.
2. Ramp up: accept duty=20, dir=0 at edge 0 -> duty 8@4, 16@8, 20@12; busy falls and at_target rises at edge 12; state HOLD.
3. Reversal: from HOLD duty 20/dir 0, accept duty=10/dir=1 -> cmd_ready=0; duty 12, 4, 0 at 4-clock ticks; duty=0 held 3 clocks; dir=1; then duty 8, 10; cmd_ready=1 throughout the final ramp.
4. Retarget mid-ramp: ramping to 100, accept 24 when duty=40 -> next ticks give 32, 24, then HOLD; no value outside 24..40 appears.
5. Estop: assert during a ramp at duty 16 -> duty=0 next edge, cmd_ready=0, cmd_valid ignored. Deassert -> IDLE; a new command is accepted; dir unchanged.
6. Saturation: ramp to 1023 from 1016 -> single tick to 1023, no wrap. Accept duty=0 from 5 -> 0 in one tick, state IDLE.
